delayed_dut_sequencer: RTL and testbench
========================================

// Module: delayed_dut_sequencer
// PURPOSE
//  Single bus master for delayed_dut's register port. Arbitrates between two write
//  requesters (operand A at addr 4, operand B at addr 5) and one result reader (Y at addr 3).
//  Before every access it polls the matching status register (0/1/2), so the DUT never
//  sees a write to a full FIFO or a read from an empty one.
// PARAMETERS
//  POLL_LIMIT  1023  consecutive failed polls before a request is abandoned (1..65535)
// PORTS
//  CLK            in   1  clock
//  RST_N          in   1  asynchronous, active-low reset
//  a_valid        in   1  requester A has a bit to write; held until a_ready
//  a_data         in   1  operand A bit
//  a_ready        out  1  1-cycle pulse: A transfer issued this cycle
//  b_valid        in   1  requester B has a bit to write; held until b_ready
//  b_data         in   1  operand B bit
//  b_ready        out  1  1-cycle pulse: B transfer issued this cycle
//  y_req          in   1  reader wants one Y bit; held until y_valid
//  y_valid        out  1  1-cycle pulse: y_data valid
//  y_data         out  1  Y result bit, registered
//  write_address  out  3  DUT write address
//  write_data     out  1  DUT write data
//  write_en       out  1  DUT write enable
//  write_rdy      in   1  DUT write ready
//  read_address   out  3  DUT read address
//  read_en        out  1  DUT read enable
//  read_data      in   1  DUT read data, combinational from read_address
//  read_rdy       in   1  DUT read ready
//  busy           out  1  state != IDLE
//  err_timeout    out  1  sticky: some request exceeded POLL_LIMIT
//  err_src        out  2  source of the first timeout (0=A, 1=B, 2=Y); frozen once set
// BEHAVIOUR
//  Reset: state=IDLE, rr pointer=A, poll_cnt=0. All outputs 0, except write_address and
//    read_address, which are 3'd0.
//  Bus outputs decode only from registered state/grant. No path from a_*/b_*/y_req to the bus.
//  IDLE: if any of {a_valid, b_valid, y_req} is set, latch the round-robin grant (search
//    starts at the rr pointer; order A->B->Y->A), latch a_data/b_data, go POLL. Else stay.
//  POLL: read_address = status addr (A:0, B:1, Y:2); read_en = read_rdy.
//    - Sample read_data only when read_rdy=1.
//    - Sample 1 -> XFER, poll_cnt=0.
//    - Sample 0 -> poll_cnt++. When poll_cnt reaches POLL_LIMIT: set err_timeout, load
//      err_src if it is the first timeout, advance rr past the grant, poll_cnt=0, go IDLE.
//      The requester is not acknowledged, so its request stays pending.
//    - read_rdy=0: hold state; poll_cnt unchanged.
//  XFER: wait in XFER until the matching ready input is 1.
//    - Write grant: write_address = 4 or 5, write_data = latched bit, write_en = write_rdy.
//      a_ready/b_ready pulses in the cycle write_en=1.
//    - Read grant: read_address = 3, read_en = read_rdy. y_data <= read_data, and y_valid
//      pulses the next cycle.
//    - On completion: rr pointer = grant+1; go IDLE.
//  Latency: best case 3 cycles per transaction (IDLE, POLL, XFER). y_valid arrives 3 cycles
//    after y_req is seen in IDLE.
//  Throughput: at most one DUT access in flight. write_en and read_en are never both 1,
//    except during an A/B POLL, which pairs read_en with write_en=0.
//  Requester inputs that drop before their ready/valid are ignored once granted. The latched
//    transfer completes anyway (protocol violation, not checked).
//  Simultaneous requests are served strictly round-robin. No requester waits more than two
//    other transactions.
//  poll_cnt is 16 bits; it saturates at POLL_LIMIT and never wraps.
//  Async reset mid-transaction: immediate return to IDLE. An in-progress write may already
//    have reached the DUT; the requester receives no ready. Software must re-issue.
// STRUCTURE
//  delayed_dut_pkg: register address constants, state enum {IDLE, POLL, XFER}, grant
//    encoding {GNT_A=0, GNT_B=1, GNT_Y=2}.
//    Address constants: ADDR_A_FULL_N=0, ADDR_B_FULL_N=1, ADDR_Y_EMPTY_N=2, ADDR_Y=3,
//    ADDR_A=4, ADDR_B=5.
//  Sub-module rr_arbiter3: 3-way round-robin with pointer register. Inputs: req[2:0],
//    advance, adv_to. Output: gnt (one-hot).
//  FSM, poll counter and bus decode live in delayed_dut_sequencer.
// TESTING (bench instantiates delayed_dut_sequencer + delayed_dut)
//  1. a_valid=1/a_data=1, then b_valid=1/b_data=0, then y_req -> after the DUT merge
//     (counter==50), y_valid pulses with y_data=1.
//  2. a_valid, b_valid, y_req all asserted at the same cycle after reset -> grants A, B, Y
//     in order. a_ready precedes b_ready by exactly 3 cycles.
//  3. Three A writes, no B -> third write polls addr 0 until POLL_LIMIT. err_timeout=1,
//     err_src=0, no third a_ready. Any B/Y requests meanwhile are still served.
//  4. POLL_LIMIT=4, y_req with DUT Y empty -> exactly 4 reads at addr 2, then
//     err_timeout=1, err_src=2, y_valid never pulses.
//  5. Deassert write_rdy/read_rdy for 5 cycles during POLL and XFER -> state held,
//     poll_cnt frozen, no enable asserted, transfer completes once ready returns.
//  6. Assert RST_N=0 during XFER of a B write -> all outputs 0 next edge, busy=0,
//     rr pointer=A, b_ready not pulsed.

Source files
------------

// File: rtl/delayed_dut_pkg.sv
// Shared constants and types for the delayed_dut register-port sequencer.
// Status registers 0..2 gate the data registers 3..5.
package delayed_dut_pkg;

  localparam logic [2:0] ADDR_A_FULL_N  = 3'd0;
  localparam logic [2:0] ADDR_B_FULL_N  = 3'd1;
  localparam logic [2:0] ADDR_Y_EMPTY_N = 3'd2;
  localparam logic [2:0] ADDR_Y         = 3'd3;
  localparam logic [2:0] ADDR_A         = 3'd4;
  localparam logic [2:0] ADDR_B         = 3'd5;

  typedef enum logic [1:0] {IDLE, POLL, XFER} state_t;
  typedef enum logic [1:0] {GNT_A = 2'd0, GNT_B = 2'd1, GNT_Y = 2'd2} gnt_t;

  function automatic logic [2:0] status_addr(input gnt_t g);
    case (g)
      GNT_A:   return ADDR_A_FULL_N;
      GNT_B:   return ADDR_B_FULL_N;
      default: return ADDR_Y_EMPTY_N;
    endcase
  endfunction

  function automatic gnt_t next_gnt(input gnt_t g);
    case (g)
      GNT_A:   return GNT_B;
      GNT_B:   return GNT_Y;
      default: return GNT_A;
    endcase
  endfunction

endpackage

// File: rtl/rr_arbiter3.sv
// Three-way round-robin arbiter: the search starts at the pointer and wraps A->B->Y->A.
// The pointer only moves when the owner says so, so abandoned requests keep their place.
module rr_arbiter3
  import delayed_dut_pkg::*;
(
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [2:0] req,
  input  logic       advance,
  input  logic [1:0] adv_to,
  output logic [2:0] gnt
);

  logic [1:0] ptr_reg;
  logic [2:0] idx;
  logic       found;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ptr_reg <= GNT_A;
    end else if (advance) begin
      ptr_reg <= adv_to;
    end
  end

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < 3; i++) begin
      idx = {1'b0, ptr_reg} + 3'(i);
      if (idx >= 3'd3) idx = idx - 3'd3;
      if (!found && req[idx[1:0]]) begin
        gnt[idx[1:0]] = 1'b1;
        found         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/delayed_dut_sequencer.sv
// Single bus master for delayed_dut: polls a status register before each access so the
// DUT never sees a write to a full FIFO or a read from an empty one.
module delayed_dut_sequencer
  import delayed_dut_pkg::*;
#(
  parameter int unsigned POLL_LIMIT = 1023
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       a_valid,
  input  logic       a_data,
  output logic       a_ready,
  input  logic       b_valid,
  input  logic       b_data,
  output logic       b_ready,
  input  logic       y_req,
  output logic       y_valid,
  output logic       y_data,
  output logic [2:0] write_address,
  output logic       write_data,
  output logic       write_en,
  input  logic       write_rdy,
  output logic [2:0] read_address,
  output logic       read_en,
  input  logic       read_data,
  input  logic       read_rdy,
  output logic       busy,
  output logic       err_timeout,
  output logic [1:0] err_src
);

  state_t      state_reg, state_next;
  gnt_t        gnt_reg, gnt_new;
  logic        data_reg;
  logic [15:0] poll_cnt_reg, poll_cnt_next;
  logic [16:0] poll_inc;
  logic        err_timeout_reg;
  logic [1:0]  err_src_reg;
  logic        y_valid_reg, y_data_reg;
  logic [2:0]  req, gnt_oh;
  logic [1:0]  adv_to;
  logic        any_req, advance, timeout_fire, y_read;

  assign req      = {y_req, b_valid, a_valid};
  assign any_req  = |req;
  assign adv_to   = next_gnt(gnt_reg);
  assign poll_inc = {1'b0, poll_cnt_reg} + 17'd1;
  assign gnt_new  = gnt_oh[0] ? GNT_A : (gnt_oh[1] ? GNT_B : GNT_Y);

  rr_arbiter3 u_arb (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .req     (req),
    .advance (advance),
    .adv_to  (adv_to),
    .gnt     (gnt_oh)
  );

  always_comb begin
    state_next    = state_reg;
    poll_cnt_next = poll_cnt_reg;
    advance       = 1'b0;
    timeout_fire  = 1'b0;
    case (state_reg)
      IDLE: if (any_req) state_next = POLL;
      POLL: begin
        if (read_rdy) begin
          if (read_data) begin
            state_next    = XFER;
            poll_cnt_next = '0;
          end else if (poll_inc >= 17'(POLL_LIMIT)) begin
            // Give up on this requester for now; it stays pending and rotates to the back.
            timeout_fire  = 1'b1;
            advance       = 1'b1;
            poll_cnt_next = '0;
            state_next    = IDLE;
          end else begin
            poll_cnt_next = poll_inc[15:0];
          end
        end
      end
      XFER: begin
        if ((gnt_reg == GNT_Y) ? read_rdy : write_rdy) begin
          advance    = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Bus decode depends only on registered state and grant, plus the DUT's own ready inputs.
  always_comb begin
    write_address = '0;
    write_data    = 1'b0;
    write_en      = 1'b0;
    read_address  = '0;
    read_en       = 1'b0;
    a_ready       = 1'b0;
    b_ready       = 1'b0;
    case (state_reg)
      POLL: begin
        read_address = status_addr(gnt_reg);
        read_en      = read_rdy;
      end
      XFER: begin
        if (gnt_reg == GNT_Y) begin
          read_address = ADDR_Y;
          read_en      = read_rdy;
        end else begin
          write_address = (gnt_reg == GNT_A) ? ADDR_A : ADDR_B;
          write_data    = data_reg;
          write_en      = write_rdy;
          a_ready       = (gnt_reg == GNT_A) && write_rdy;
          b_ready       = (gnt_reg == GNT_B) && write_rdy;
        end
      end
      default: ;
    endcase
  end

  assign y_read = (state_reg == XFER) && (gnt_reg == GNT_Y) && read_rdy;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg       <= IDLE;
      gnt_reg         <= GNT_A;
      data_reg        <= 1'b0;
      poll_cnt_reg    <= '0;
      err_timeout_reg <= 1'b0;
      err_src_reg     <= '0;
      y_valid_reg     <= 1'b0;
      y_data_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      poll_cnt_reg <= poll_cnt_next;
      y_valid_reg  <= y_read;
      if (y_read) y_data_reg <= read_data;
      if (state_reg == IDLE && any_req) begin
        gnt_reg  <= gnt_new;
        data_reg <= gnt_oh[0] ? a_data : b_data;
      end
      if (timeout_fire) begin
        err_timeout_reg <= 1'b1;
        if (!err_timeout_reg) err_src_reg <= gnt_reg;
      end
    end
  end

  assign busy        = (state_reg != IDLE);
  assign y_valid     = y_valid_reg;
  assign y_data      = y_data_reg;
  assign err_timeout = err_timeout_reg;
  assign err_src     = err_src_reg;

endmodule

// File: tb/tb_delayed_dut_sequencer.sv
// Bench for delayed_dut_sequencer with a queue-level model of delayed_dut: two-deep A/B/Y
// FIFOs whose heads merge (Y = A ^ B) after a fixed delay.
module tb_delayed_dut_sequencer;

  localparam int POLL_LIMIT  = 4;
  localparam int MERGE_DELAY = 50;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       a_valid = 1'b0, a_data = 1'b0, a_ready;
  logic       b_valid = 1'b0, b_data = 1'b0, b_ready;
  logic       y_req = 1'b0, y_valid, y_data;
  logic [2:0] write_address, read_address;
  logic       write_data, write_en, read_en, read_data;
  logic       write_rdy = 1'b1, read_rdy = 1'b1;
  logic       busy, err_timeout;
  logic [1:0] err_src;

  int n_tests = 0, n_fail = 0;
  int n_a, n_b, n_y, n_poll_y, cyc_cnt = 0, a_cyc, b_cyc, y_cyc;
  bit exp_a[$], exp_b[$];
  int order_q[$];

  always #5 CLK = ~CLK;

  delayed_dut_sequencer #(.POLL_LIMIT(POLL_LIMIT)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
    .y_req(y_req), .y_valid(y_valid), .y_data(y_data),
    .write_address(write_address), .write_data(write_data), .write_en(write_en),
    .write_rdy(write_rdy),
    .read_address(read_address), .read_en(read_en), .read_data(read_data),
    .read_rdy(read_rdy),
    .busy(busy), .err_timeout(err_timeout), .err_src(err_src)
  );

  // FIFO state packed as {count[1:0], mem1, mem0}; pop happens before push.
  logic [3:0] a_st, b_st, y_st;
  int         merge_tmr;
  logic       merge_ok, merge_fire;

  function automatic logic [3:0] fstep(input logic [3:0] s, input logic pop,
                                       input logic push, input logic din);
    logic [1:0] c;
    logic       m0, m1;
    {c, m1, m0} = s;
    if (pop && c != 2'd0) begin m0 = m1; c = c - 2'd1; end
    if (push && c != 2'd2) begin
      if (c == 2'd0) m0 = din; else m1 = din;
      c = c + 2'd1;
    end
    return {c, m1, m0};
  endfunction

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      a_st <= '0; b_st <= '0; y_st <= '0; merge_tmr <= 0;
    end else begin
      merge_ok   = (a_st[3:2] != 0) && (b_st[3:2] != 0) && (y_st[3:2] != 2);
      merge_fire = merge_ok && (merge_tmr == MERGE_DELAY - 1);
      merge_tmr <= (merge_ok && !merge_fire) ? merge_tmr + 1 : 0;
      a_st <= fstep(a_st, merge_fire, write_en && write_address == 3'd4, write_data);
      b_st <= fstep(b_st, merge_fire, write_en && write_address == 3'd5, write_data);
      y_st <= fstep(y_st, read_en && read_address == 3'd3, merge_fire, a_st[0] ^ b_st[0]);
    end
  end

  always_comb begin
    read_data = 1'b0;
    case (read_address)
      3'd0: read_data = (a_st[3:2] != 2'd2);
      3'd1: read_data = (b_st[3:2] != 2'd2);
      3'd2: read_data = (y_st[3:2] != 2'd0);
      3'd3: read_data = y_st[0];
      default: read_data = 1'b0;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Per-cycle protocol checks and scoreboard, sampled mid-cycle.
  task automatic monitor();
    logic exp_y;
    cyc_cnt++;
    if (!RST_N) return;
    check("bus_excl", {31'd0, write_en & read_en}, 0);
    check("en_rdy", {31'd0, (write_en & ~write_rdy) | (read_en & ~read_rdy)}, 0);
    if (write_en)
      check("wr_room", {31'd0, (write_address == 3'd4) ? (a_st[3:2] != 2'd2) : (b_st[3:2] != 2'd2)}, 1);
    if (read_en && read_address == 3'd3) check("rd_avail", {31'd0, y_st[3:2] != 2'd0}, 1);
    if (read_en && read_address == 3'd2) n_poll_y++;
    if (a_ready) begin
      check("a_wr", {27'd0, write_en, write_address, write_data}, {27'd0, 1'b1, 3'd4, a_data});
      exp_a.push_back(a_data); n_a++; a_cyc = cyc_cnt; order_q.push_back(0); a_valid = 1'b0;
      $display("[TB] t=%0t A write %0d", $time, a_data);
    end
    if (b_ready) begin
      check("b_wr", {27'd0, write_en, write_address, write_data}, {27'd0, 1'b1, 3'd5, b_data});
      exp_b.push_back(b_data); n_b++; b_cyc = cyc_cnt; order_q.push_back(1); b_valid = 1'b0;
      $display("[TB] t=%0t B write %0d", $time, b_data);
    end
    if (y_valid) begin
      check("y_sb", {31'd0, exp_a.size() > 0 && exp_b.size() > 0}, 1);
      if (exp_a.size() > 0 && exp_b.size() > 0) begin
        exp_y = exp_a.pop_front() ^ exp_b.pop_front();
        check("y_data", {31'd0, y_data}, {31'd0, exp_y});
      end
      n_y++; y_cyc = cyc_cnt; order_q.push_back(2); y_req = 1'b0;
      $display("[TB] t=%0t Y read %0d", $time, y_data);
    end
  endtask

  task automatic cyc();
    @(negedge CLK);
    monitor();
    @(posedge CLK);
    #1;
  endtask

  function automatic int evt(input int which);
    case (which)
      0: return n_a;
      1: return n_b;
      2: return n_y;
      3: return int'(err_timeout);
      default: return int'(y_st[3:2] != 2'd0);
    endcase
  endfunction

  task automatic wait_evt(input int which, input int budget, input string tag);
    int start;
    start = evt(which);
    for (int i = 0; i < budget && evt(which) == start; i++) cyc();
    check(tag, {31'd0, evt(which) != start}, 1);
  endtask

  task automatic clear_sb();
    exp_a.delete(); exp_b.delete(); order_q.delete();
    n_a = 0; n_b = 0; n_y = 0; n_poll_y = 0;
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    a_valid = 0; b_valid = 0; y_req = 0; a_data = 0; b_data = 0;
    write_rdy = 1; read_rdy = 1;
    clear_sb();
    cyc(); cyc();
    check("rst_outs", {15'd0, busy, write_en, write_address, write_data, read_en, read_address,
                       a_ready, b_ready, y_valid, y_data, err_timeout, err_src}, 0);
    RST_N = 1'b1;
    cyc();
  endtask

  int k, start;

  initial begin
    // 1: A=1, B=0, then Y after the merge; also first-transaction latencies.
    do_reset();
    k = cyc_cnt; a_valid = 1; a_data = 1;
    wait_evt(0, 20, "t1_a");
    check("t1_a_lat", a_cyc - k, 3);
    b_valid = 1; b_data = 0;
    wait_evt(1, 20, "t1_b");
    wait_evt(4, 200, "t1_merge");
    k = cyc_cnt; y_req = 1;
    wait_evt(2, 20, "t1_y");
    check("t1_y_lat", y_cyc - k, 4);
    check("t1_ydata", {31'd0, y_data}, 1);

    // 2: simultaneous requests served A, B, Y.
    do_reset();
    a_valid = 1; a_data = 1'($urandom); b_valid = 1; b_data = 1'($urandom); y_req = 1;
    wait_evt(2, 400, "t2_y");
    check("t2_order", (order_q.size() == 3) ? order_q[0] * 100 + order_q[1] * 10 + order_q[2] : 999, 12);
    check("t2_ab_gap", b_cyc - a_cyc, 3);

    // 3: third A write times out on a full FIFO; B still gets through.
    do_reset();
    for (int i = 0; i < 2; i++) begin
      a_valid = 1; a_data = 1'($urandom);
      wait_evt(0, 20, "t3_a");
    end
    a_valid = 1; a_data = 1'($urandom);
    wait_evt(3, 40, "t3_to");
    check("t3_err", {29'd0, err_timeout, err_src}, {29'd0, 1'b1, 2'd0});
    check("t3_no_a3", n_a, 2);
    b_valid = 1; b_data = 1'($urandom);
    wait_evt(1, 40, "t3_b");
    wait_evt(0, 200, "t3_a3");
    check("t3_src_frozen", {30'd0, err_src}, 0);

    // 4: Y empty -> exactly POLL_LIMIT status reads, then timeout with err_src=Y.
    do_reset();
    y_req = 1;
    wait_evt(3, 40, "t4_to");
    y_req = 0;
    check("t4_polls", n_poll_y, POLL_LIMIT);
    check("t4_err", {29'd0, err_timeout, err_src}, {29'd0, 1'b1, 2'd2});
    check("t4_no_y", n_y, 0);

    // 5: ready stalls in POLL and XFER hold state without enables or timeouts.
    do_reset();
    write_rdy = 0; read_rdy = 0; a_valid = 1; a_data = 0;
    cyc();
    for (int i = 0; i < 5; i++) begin
      check("t5_poll_hold", {26'd0, busy, read_en, write_en, read_address}, {26'd0, 3'b100, 3'd0});
      cyc();
    end
    check("t5_no_to", {31'd0, err_timeout}, 0);
    read_rdy = 1;
    cyc();
    for (int i = 0; i < 5; i++) begin
      check("t5_xfer_hold", {25'd0, busy, write_en, read_en, a_ready, write_address},
            {25'd0, 4'b1000, 3'd4});
      cyc();
    end
    start = n_a; write_rdy = 1;
    cyc();
    check("t5_done", n_a - start, 1);

    // 6: async reset during a stalled B XFER; pointer must return to A.
    do_reset();
    a_valid = 1; a_data = 1;
    wait_evt(0, 20, "t6_a0");
    write_rdy = 0; b_valid = 1; b_data = 1;
    cyc(); cyc(); cyc();
    check("t6_in_xfer", {28'd0, busy, write_address}, {28'd0, 1'b1, 3'd5});
    RST_N = 1'b0;
    #1;
    check("t6_rst_outs", {18'd0, busy, write_en, write_address, write_data, read_en, read_address,
                          a_ready, b_ready, y_valid}, 0);
    b_valid = 0; clear_sb();
    cyc(); cyc();
    RST_N = 1'b1; write_rdy = 1;
    a_valid = 1; a_data = 0; b_valid = 1; b_data = 1;
    wait_evt(0, 20, "t6_a1");
    check("t6_first", (order_q.size() > 0) ? order_q[0] : 9, 0);
    check("t6_b_after", n_b, 0);

    // Random traffic with random ready stalls.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if (!a_valid && $urandom_range(3) == 0) begin a_valid = 1; a_data = 1'($urandom); end
      if (!b_valid && $urandom_range(3) == 0) begin b_valid = 1; b_data = 1'($urandom); end
      if (!y_req && $urandom_range(7) == 0) y_req = 1;
      write_rdy = ($urandom_range(3) != 0);
      read_rdy  = ($urandom_range(3) != 0);
      cyc();
    end
    check("rand_progress", {31'd0, n_y > 5}, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
